// File: rtl/regfile_mp_sb.sv
// Multi-read, dual-write-back register file with same-cycle bypass and a
// per-register busy scoreboard for decode-stage hazard detection.
module regfile_mp_sb #(
  parameter int XLEN  = 32,
  parameter int NREGS = 32,
  parameter int NREAD = 2
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [NREAD*$clog2(NREGS)-1:0] rd_addr,
  output logic [NREAD*XLEN-1:0]       rd_data,
  output logic [NREAD-1:0]            rd_busy,
  input  logic                        wb0_en,
  input  logic [$clog2(NREGS)-1:0]    wb0_addr,
  input  logic [XLEN-1:0]             wb0_data,
  input  logic                        wb1_en,
  input  logic [$clog2(NREGS)-1:0]    wb1_addr,
  input  logic [XLEN-1:0]             wb1_data,
  input  logic                        iss_en,
  input  logic [$clog2(NREGS)-1:0]    iss_rd,
  input  logic                        flush,
  output logic [NREGS-1:0]            busy_vec
);

  localparam int AW = $clog2(NREGS);

  logic [XLEN-1:0]  mem [NREGS];
  logic [NREGS-1:0] busy;

  // wb1 is written second so it wins a same-address collision.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int r = 0; r < NREGS; r++) mem[r] <= '0;
    end else begin
      if (wb0_en && (wb0_addr != '0)) mem[wb0_addr] <= wb0_data;
      if (wb1_en && (wb1_addr != '0)) mem[wb1_addr] <= wb1_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy <= '0;
    end else begin
      busy[0] <= 1'b0;
      for (int r = 1; r < NREGS; r++) begin
        if (flush)
          busy[r] <= 1'b0;
        else if (iss_en && (iss_rd == AW'(r)))
          busy[r] <= 1'b1;
        else if ((wb0_en && (wb0_addr == AW'(r))) || (wb1_en && (wb1_addr == AW'(r))))
          busy[r] <= 1'b0;
      end
    end
  end

  assign busy_vec = busy;

  for (genvar i = 0; i < NREAD; i++) begin : g_rd
    logic [AW-1:0] a;
    logic          hit0;
    logic          hit1;
    logic          live;

    assign a    = rd_addr[i*AW +: AW];
    assign hit0 = wb0_en && (wb0_addr == a);
    assign hit1 = wb1_en && (wb1_addr == a);
    // Reads are forced to zero while reset is held so bypass cannot leak through.
    assign live = rst_n && (a != '0);

    assign rd_data[i*XLEN +: XLEN] = !live ? '0 :
                                     hit1  ? wb1_data :
                                     hit0  ? wb0_data : mem[a];
    assign rd_busy[i] = live && busy[a] && !(hit0 || hit1);
  end

endmodule

// File: tb/tb_regfile_mp_sb.sv
// Directed bench for regfile_mp_sb: stimulus pushes expectations into a queue,
// a negedge monitor pops and compares them against the live outputs.
module tb_regfile_mp_sb;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [9:0]  rd_addr;
  logic [63:0] rd_data;
  logic [1:0]  rd_busy;
  logic        wb0_en, wb1_en, iss_en, flush;
  logic [4:0]  wb0_addr, wb1_addr, iss_rd;
  logic [31:0] wb0_data, wb1_data;
  logic [31:0] busy_vec;

  regfile_mp_sb #(.XLEN(32), .NREGS(32), .NREAD(2)) dut (
    .clk(clk), .rst_n(rst_n),
    .rd_addr(rd_addr), .rd_data(rd_data), .rd_busy(rd_busy),
    .wb0_en(wb0_en), .wb0_addr(wb0_addr), .wb0_data(wb0_data),
    .wb1_en(wb1_en), .wb1_addr(wb1_addr), .wb1_data(wb1_data),
    .iss_en(iss_en), .iss_rd(iss_rd), .flush(flush),
    .busy_vec(busy_vec)
  );

  always #5 clk = ~clk;

  // kind: 0 = rd_data[port], 1 = rd_busy[port], 2 = busy_vec
  typedef struct {
    string       name;
    int          kind;
    int          port;
    logic [31:0] val;
  } exp_t;

  exp_t q[$];
  int   n_checks = 0;
  int   n_pass   = 0;

  function automatic void push(string nm, int kind, int port, logic [31:0] v);
    exp_t e;
    e.name = nm; e.kind = kind; e.port = port; e.val = v;
    q.push_back(e);
  endfunction

  function automatic void exp_rd(string nm, int port, logic [31:0] d, logic b);
    push({nm, "_data"}, 0, port, d);
    push({nm, "_busy"}, 1, port, {31'b0, b});
  endfunction

  function automatic void exp_bv(string nm, logic [31:0] v);
    push(nm, 2, 0, v);
  endfunction

  always begin
    @(negedge clk);
    while (q.size() > 0) begin
      exp_t        e;
      logic [31:0] act;
      e = q.pop_front();
      case (e.kind)
        0:       act = rd_data[e.port*32 +: 32];
        1:       act = {31'b0, rd_busy[e.port]};
        default: act = busy_vec;
      endcase
      n_checks++;
      if (act === e.val) n_pass++;
      else $display("FAIL %s: got %h expected %h", e.name, act, e.val);
    end
  end

  task automatic idle();
    wb0_en = 0; wb1_en = 0; iss_en = 0; flush = 0;
    wb0_addr = 0; wb1_addr = 0; iss_rd = 0; wb0_data = 0; wb1_data = 0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    idle();
  endtask

  task automatic set_rd(input logic [4:0] a0, input logic [4:0] a1);
    rd_addr = {a1, a0};
  endtask

  task automatic wb0(input logic [4:0] a, input logic [31:0] d);
    wb0_en = 1; wb0_addr = a; wb0_data = d;
  endtask

  task automatic wb1(input logic [4:0] a, input logic [31:0] d);
    wb1_en = 1; wb1_addr = a; wb1_data = d;
  endtask

  task automatic iss(input logic [4:0] a);
    iss_en = 1; iss_rd = a;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n = 0;
    idle();
    set_rd(5, 6);
    // Bypass and issue must be inert while reset is held.
    wb0(5, 32'h99);
    iss(5);
    exp_rd("in_reset_p0", 0, 0, 0);
    exp_rd("in_reset_p1", 1, 0, 0);
    exp_bv("in_reset_bv", 0);
    #12;
    idle();
    rst_n = 1;

    step(); set_rd(5, 6);
    exp_rd("post_reset_p0", 0, 0, 0);
    exp_rd("post_reset_p1", 1, 0, 0);
    exp_bv("post_reset_bv", 0);

    step(); wb0(5, 32'h5); set_rd(5, 6);
    exp_rd("bypass_x5", 0, 32'h5, 0);

    step(); set_rd(5, 6);
    exp_rd("stored_x5", 0, 32'h5, 0);

    step(); wb0(7, 32'h1111_1111); wb1(7, 32'h2222_2222); set_rd(5, 7);
    exp_rd("collide_bypass_x7", 1, 32'h2222_2222, 0);

    step(); set_rd(5, 7);
    exp_rd("collide_stored_x7", 1, 32'h2222_2222, 0);
    exp_rd("still_x5", 0, 32'h5, 0);

    step(); wb0(0, 32'hDEAD_BEEF); iss(0); set_rd(0, 7);
    exp_rd("x0_bypass", 0, 0, 0);

    step(); set_rd(0, 7);
    exp_rd("x0_stored", 0, 0, 0);
    exp_bv("x0_not_busy", 0);

    step(); iss(9); set_rd(0, 9);
    exp_rd("iss_same_cycle", 1, 0, 0);
    exp_bv("iss_same_cycle_bv", 0);

    step(); set_rd(0, 9);
    exp_rd("x9_busy", 1, 0, 1);
    exp_bv("x9_busy_bv", 32'h0000_0200);

    step(); wb1(9, 32'h42); set_rd(0, 9);
    exp_rd("x9_wb1_bypass", 1, 32'h42, 0);
    exp_bv("x9_wb_cycle_bv", 32'h0000_0200);

    step(); set_rd(0, 9);
    exp_rd("x9_after_wb", 1, 32'h42, 0);
    exp_bv("x9_cleared_bv", 0);

    step(); iss(9); wb0(9, 32'h55); set_rd(0, 9);
    exp_rd("waw_bypass", 1, 32'h55, 0);

    step(); set_rd(0, 9);
    exp_rd("waw_busy", 1, 32'h55, 1);
    exp_bv("waw_bv", 32'h0000_0200);

    step(); iss(3);
    exp_bv("iss3_bv", 32'h0000_0200);
    step(); iss(4);
    exp_bv("iss4_bv", 32'h0000_0208);
    step(); iss(8);
    exp_bv("iss8_bv", 32'h0000_0218);

    step(); flush = 1; iss(10); wb0(4, 32'h7); set_rd(4, 9);
    exp_bv("pre_flush_bv", 32'h0000_0318);

    step(); iss(12); set_rd(4, 12);
    exp_bv("flushed_bv", 0);
    exp_rd("x4_written_in_flush", 0, 32'h7, 0);

    // Pulse reset between clock edges; state must clear before the next edge.
    step(); set_rd(4, 12);
    #1 rst_n = 0;
    #1 rst_n = 1;
    exp_rd("async_reset_x4", 0, 0, 0);
    exp_rd("async_reset_x12", 1, 0, 0);
    exp_bv("async_reset_bv", 0);

    step(); wb0(13, 32'hA); wb1(14, 32'hB); set_rd(13, 14);
    exp_rd("dual_bypass_x13", 0, 32'hA, 0);
    exp_rd("dual_bypass_x14", 1, 32'hB, 0);

    step(); set_rd(13, 14);
    exp_rd("dual_stored_x13", 0, 32'hA, 0);
    exp_rd("dual_stored_x14", 1, 32'hB, 0);

    @(negedge clk);
    #1;
    n_checks++;
    if (q.size() == 0) n_pass++;
    else $display("FAIL queue_drain: got %0d pending expected 0", q.size());

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
